// File: rtl/crc_pkg.sv
// ---------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the serial CRC-24A attachment stage:
//   - state_e        : framing FSM states
//   - CRC_W, POLY    : CRC-24A length and generator (x^24 implied)
//   - K_SMALL/K_LARGE: code block sizes, CRC included
//   - L_SMALL/L_LARGE: payload lengths (block size minus CRC)
//   - CNT_W          : bit counter width
// ---------------------------------------------------------------------------
package crc_pkg;

  localparam int          CRC_W   = 24;
  localparam logic [23:0] POLY    = 24'h864CFB;
  localparam int          K_SMALL = 1056;
  localparam int          K_LARGE = 6144;
  localparam int          L_SMALL = K_SMALL - CRC_W;  // 1032
  localparam int          L_LARGE = K_LARGE - CRC_W;  // 6120
  localparam int          CNT_W   = 13;

  typedef enum logic [2:0] {
    IDLE,
    START,
    GAP,
    DATA,
    CRC,
    DONE
  } state_e;

  // Counter value of the last payload bit for the selected block size.
  function automatic logic [CNT_W-1:0] last_payload_idx(input logic bsz);
    return bsz ? CNT_W'(L_LARGE - 1) : CNT_W'(L_SMALL - 1);
  endfunction

endpackage

// File: rtl/crc24_lfsr.sv
// ---------------------------------------------------------------------------
// crc24_lfsr
// 24-bit MSB-first CRC-24A register with three operations (priority order):
//   clr       : load zero
//   upd       : absorb din  (fb = msb ^ din; shift left; xor POLY if fb)
//   shift_out : shift left, zero fill, so the remainder leaves MSB first
// Ports:
//   clk, reset_n  : clock, synchronous active-low reset
//   clr, upd, shift_out, din : operation controls and data bit
//   msb           : current register MSB (next CRC bit to transmit)
// ---------------------------------------------------------------------------
module crc24_lfsr
  import crc_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic upd,
  input  logic shift_out,
  input  logic din,
  output logic msb
);

  logic [CRC_W-1:0] lfsr_q, lfsr_d;
  logic             fb;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch is inferred when no branch matches.
  always_comb begin
    fb     = lfsr_q[CRC_W-1] ^ din;
    lfsr_d = lfsr_q;
    if (clr) begin
      lfsr_d = '0;
    end else if (upd) begin
      lfsr_d = {lfsr_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end else if (shift_out) begin
      lfsr_d = {lfsr_q[CRC_W-2:0], 1'b0};
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) lfsr_q <= '0;
    else          lfsr_q <= lfsr_d;
  end

  assign msb = lfsr_q[CRC_W-1];

endmodule

// File: rtl/crc24_attach.sv
// ---------------------------------------------------------------------------
// crc24_attach
// Serial CRC-24A attachment: passes payload bits straight through and then
// appends the 24-bit CRC, producing one contiguous K-bit block framed by
// CRC_start (two cycles ahead of bit 0) and CRC_END (with the last CRC bit).
// Ports:
//   clk, reset_n         : clock, synchronous active-low reset
//   in_start             : block request, honoured only in IDLE
//   in_block_size        : 0 -> K=1056, 1 -> K=6144, captured with in_start
//   in_valid, in_data    : payload bit stream, one bit per cycle in DATA
//   in_ready             : payload accepted (DATA phase)
//   CRC_start            : one-cycle frame start
//   CRC_data, CRC_valid  : serial output bit and its qualifier
//   CRC_END              : last CRC bit marker (tied low when END_EN=0)
//   block_size           : captured size, held until the next accepted start
//   busy                 : block in progress
//   err                  : one-cycle payload underrun pulse
// ---------------------------------------------------------------------------
module crc24_attach
  import crc_pkg::*;
#(
  parameter logic END_EN = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_start,
  input  logic in_block_size,
  input  logic in_valid,
  input  logic in_data,
  output logic in_ready,
  output logic CRC_start,
  output logic CRC_data,
  output logic CRC_valid,
  output logic CRC_END,
  output logic block_size,
  output logic busy,
  output logic err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bsz_q, bsz_d;
  logic             lfsr_clr, lfsr_upd, lfsr_shift, lfsr_msb;

  crc24_lfsr u_lfsr (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (lfsr_clr),
    .upd       (lfsr_upd),
    .shift_out (lfsr_shift),
    .din       (in_data),
    .msb       (lfsr_msb)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bsz_d      = bsz_q;
    lfsr_clr   = 1'b0;
    lfsr_upd   = 1'b0;
    lfsr_shift = 1'b0;
    in_ready   = 1'b0;
    CRC_start  = 1'b0;
    CRC_data   = 1'b0;
    CRC_valid  = 1'b0;
    CRC_END    = 1'b0;
    err        = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_start) begin
          state_d  = START;
          bsz_d    = in_block_size;
          cnt_d    = '0;
          lfsr_clr = 1'b1;
        end
      end
      START: begin
        CRC_start = 1'b1;
        state_d   = GAP;
      end
      GAP: begin
        state_d = DATA;
      end
      DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Zero-latency pass-through; the LFSR absorbs the same bit.
          CRC_data  = in_data;
          CRC_valid = 1'b1;
          lfsr_upd  = 1'b1;
          if (cnt_q == last_payload_idx(bsz_q)) begin
            state_d = CRC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // A gap in the payload breaks block contiguity: drop the block.
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      CRC: begin
        CRC_data   = lfsr_msb;
        CRC_valid  = 1'b1;
        lfsr_shift = 1'b1;
        if (cnt_q == CNT_W'(CRC_W - 1)) begin
          CRC_END = END_EN;
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bsz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bsz_q   <= bsz_d;
    end
  end

  assign block_size = bsz_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_crc24_attach.sv
// ---------------------------------------------------------------------------
// tb_crc24_attach
// Table-driven block scenarios plus hand-written reset sequences. Two DUT
// copies share all inputs: END_EN=1 (main) and END_EN=0 (CRC_END suppressed).
// Expected CRC bits come from polynomial long division of the payload
// times x^24 by the CRC-24A generator; whole codewords must divide evenly.
// ---------------------------------------------------------------------------
module tb_crc24_attach;

  localparam logic [23:0] GEN  = 24'h864CFB;
  localparam int          KS   = 1056;
  localparam int          KL   = 6144;

  logic clk = 1'b0;
  logic reset_n, in_start, in_block_size, in_valid, in_data;
  logic in_ready, crc_start, crc_data, crc_valid, crc_end, bsz_o, busy, err;
  logic in_ready2, crc_start2, crc_data2, crc_valid2, crc_end2, bsz_o2, busy2, err2;

  int n_cmp = 0;
  int n_bad = 0;

  bit payload [KL];
  bit cw      [KL];
  bit cw2     [KL];
  bit seq     [KL];

  typedef struct {
    bit bsz;         // in_block_size
    int pat;         // 0 all-zero, 1 random, 2 single leading one
    int drop_at;     // payload index where in_valid drops, -1 none
    bit noise;       // extra in_start pulses in DATA and DONE
    int exp_nvalid;  // valid output bits expected
    int exp_end;     // CRC_END cycle, -1 none
    int exp_err;     // err cycle, -1 none
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  crc24_attach #(.END_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .in_start(in_start),
    .in_block_size(in_block_size), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .CRC_start(crc_start), .CRC_data(crc_data),
    .CRC_valid(crc_valid), .CRC_END(crc_end), .block_size(bsz_o),
    .busy(busy), .err(err)
  );

  crc24_attach #(.END_EN(1'b0)) dut_ne (
    .clk(clk), .reset_n(reset_n), .in_start(in_start),
    .in_block_size(in_block_size), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .CRC_start(crc_start2), .CRC_data(crc_data2),
    .CRC_valid(crc_valid2), .CRC_END(crc_end2), .block_size(bsz_o2),
    .busy(busy2), .err(err2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Remainder of the polynomial whose coefficients are seq[0..n-1]
  // (highest power first) modulo the CRC-24A generator.
  function automatic logic [23:0] poly_mod(input int n);
    logic [23:0] r = '0;
    logic        top;
    for (int i = 0; i < n; i++) begin
      top = r[23];
      r   = {r[22:0], seq[i]};
      if (top) r = r ^ GEN;
    end
    return r;
  endfunction

  function automatic logic [5:0] all_outs();
    return {in_ready | in_ready2, crc_start | crc_start2, crc_data | crc_data2,
            crc_valid | crc_valid2, crc_end | crc_end2, err | err2};
  endfunction

  task automatic run_block(input int idx, input vec_t v);
    int K    = v.bsz ? KL : KS;
    int L    = K - 24;
    int last = (v.drop_at >= 0) ? 3 + v.drop_at + 1 : K + 4;
    int stop_ready = (v.drop_at >= 0) ? 3 + v.drop_at + 1 : 3 + L;
    int n_start = 0, first_start = -1, n_end = 0, end_c = -1;
    int n_err = 0, err_c = -1, nvalid = 0, first_v = -1, last_v = -1;
    int nvalid2 = 0, n_end2 = 0;
    int bad_ready = 0, bad_busy = 0, bad_bsz = 0, bad_pay = 0, bad_ne = 0;
    int p;
    logic [23:0] exp_crc, got_crc;
    string tag = $sformatf("v%0d", idx);

    for (int i = 0; i < L; i++) begin
      case (v.pat)
        0:       payload[i] = 1'b0;
        2:       payload[i] = (i == 0);
        default: payload[i] = 1'($urandom);
      endcase
    end

    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      in_start      = (c == 0) || (v.noise && (c == 100 || c == K + 3));
      in_block_size = (c == 0) ? v.bsz : ~v.bsz;
      p = c - 3;
      if (c >= 3 && p < L && p != v.drop_at) begin
        in_valid = 1'b1;
        in_data  = payload[p];
      end else if (p == v.drop_at) begin
        in_valid = 1'b0;
        in_data  = 1'($urandom);
      end else begin
        in_valid = 1'($urandom);
        in_data  = 1'($urandom);
      end
      #1;
      if (crc_start) begin
        n_start++;
        if (first_start < 0) first_start = c;
      end
      if (crc_valid) begin
        if (nvalid < KL) cw[nvalid] = crc_data;
        nvalid++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (crc_valid2) begin
        if (nvalid2 < KL) cw2[nvalid2] = crc_data2;
        nvalid2++;
      end
      if (crc_end)  begin n_end++; end_c = c; end
      if (crc_end2) n_end2++;
      if (err)      begin n_err++; err_c = c; end
      if (in_ready !== (c >= 3 && c < stop_ready)) bad_ready++;
      if (in_ready2 !== (c >= 3 && c < stop_ready)) bad_ready++;
      if (busy  !== (c >= 1 && c < last)) bad_busy++;
      if (busy2 !== (c >= 1 && c < last)) bad_busy++;
      if (c >= 1 && (bsz_o !== v.bsz || bsz_o2 !== v.bsz)) bad_bsz++;
    end

    check({tag, " start_cycle"}, first_start, 1);
    check({tag, " start_pulses"}, n_start, 1);
    check({tag, " valid_count"}, nvalid, v.exp_nvalid);
    check({tag, " valid_first_cycle"}, first_v, 3);
    check({tag, " valid_contiguous"}, last_v - first_v + 1, nvalid);
    check({tag, " end_cycle"}, end_c, v.exp_end);
    check({tag, " end_pulses"}, n_end, (v.exp_end >= 0) ? 1 : 0);
    check({tag, " err_cycle"}, err_c, v.exp_err);
    check({tag, " err_pulses"}, n_err, (v.exp_err >= 0) ? 1 : 0);
    check({tag, " in_ready_bad_cycles"}, bad_ready, 0);
    check({tag, " busy_bad_cycles"}, bad_busy, 0);
    check({tag, " block_size_bad_cycles"}, bad_bsz, 0);
    check({tag, " noend_dut_end_pulses"}, n_end2, 0);
    check({tag, " noend_dut_valid_count"}, nvalid2, v.exp_nvalid);

    for (int i = 0; i < L && i < nvalid; i++)
      if (cw[i] != payload[i]) bad_pay++;
    check({tag, " payload_bad_bits"}, bad_pay, 0);

    if (v.exp_end >= 0) begin
      for (int i = 0; i < L; i++)  seq[i] = payload[i];
      for (int i = L; i < K; i++)  seq[i] = 1'b0;
      exp_crc = poly_mod(K);
      got_crc = '0;
      for (int i = 0; i < 24; i++) got_crc = {got_crc[22:0], cw[L + i]};
      check({tag, " crc_bits"}, int'(got_crc), int'(exp_crc));
      for (int i = 0; i < K; i++) seq[i] = cw[i];
      check({tag, " codeword_remainder"}, int'(poly_mod(K)), 0);
      for (int i = 0; i < K && i < nvalid2; i++)
        if (cw2[i] != ((i < L) ? payload[i] : exp_crc[23 - (i - L)])) bad_ne++;
    end else begin
      for (int i = 0; i < L && i < nvalid2; i++)
        if (cw2[i] != payload[i]) bad_ne++;
    end
    check({tag, " noend_dut_bad_bits"}, bad_ne, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{bsz: 1'b0, pat: 0, drop_at: -1,  noise: 1'b0, exp_nvalid: 1056, exp_end: 1058, exp_err: -1};
    vecs[1] = '{bsz: 1'b1, pat: 1, drop_at: -1,  noise: 1'b1, exp_nvalid: 6144, exp_end: 6146, exp_err: -1};
    vecs[2] = '{bsz: 1'b0, pat: 2, drop_at: -1,  noise: 1'b0, exp_nvalid: 1056, exp_end: 1058, exp_err: -1};
    vecs[3] = '{bsz: 1'b0, pat: 1, drop_at: 500, noise: 1'b0, exp_nvalid: 500,  exp_end: -1,   exp_err: 503};
    vecs[4] = '{bsz: 1'b0, pat: 1, drop_at: -1,  noise: 1'b1, exp_nvalid: 1056, exp_end: 1058, exp_err: -1};

    // Reset with noisy inputs: every output must be idle.
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_start      = 1'($urandom);
      in_block_size = 1'($urandom);
      in_valid      = 1'($urandom);
      in_data       = 1'($urandom);
      #1;
      if (c > 0) begin
        check("reset_outputs", int'(all_outs()), 0);
        check("reset_busy", int'(busy | busy2), 0);
        check("reset_block_size", int'(bsz_o | bsz_o2), 0);
      end
    end
    @(negedge clk);
    reset_n  = 1'b1;
    in_start = 1'b0;

    for (int i = 0; i < 5; i++) run_block(i, vecs[i]);

    // Reset during CRC bit 10 of a small block.
    begin
      int r = 3 + 1032 + 10;
      int nv = 0;
      for (int c = 0; c <= r + 1; c++) begin
        @(negedge clk);
        in_start      = (c == 0);
        in_block_size = 1'b0;
        in_valid      = (c >= 3 && c < 3 + 1032) ? 1'b1 : 1'($urandom);
        in_data       = 1'($urandom);
        reset_n       = (c != r);
        #1;
        if (c <= r && crc_valid) nv++;
        if (c == r) check("rst_crc_bit10_valid", int'(crc_valid), 1);
        if (c == r + 1) begin
          check("rst_abort_outputs", int'(all_outs()), 0);
          check("rst_abort_busy", int'(busy | busy2), 0);
          check("rst_abort_block_size", int'(bsz_o | bsz_o2), 0);
        end
      end
      check("rst_valid_before_abort", nv, 1032 + 11);
    end
    run_block(5, vecs[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
